uart_wb_fifo: RTL and testbench

- Second-generation Wishbone front end for the existing `uart` serial core.
- Provides a 4-register map (data, status, interrupt enable, FIFO levels), parametrised TX/RX FIFO depths, sticky error flags and a level-sensitive interrupt.
- Drives the core's transmit/tx_byte handshake through an explicit state machine that waits for the core's busy signal.
- Sits between the Wishbone bus (16-bit data) and one `uart` instance; the serial pins stay on the core.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/uart_wb_fifo.sv | 133 +++++++++++++
 tb/tb_uart_wb_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and TX FSM states for uart_wb_fifo
package uart_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;
    localparam logic [1:0] REG_LEVELS = 2'd3;
    localparam int ST_RX_EMPTY  = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_FULL   = 3;
    localparam int ST_TX_ACTIVE = 4;
    localparam int ST_RXOVR     = 5;
    localparam int ST_TXOVF     = 6;
    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a full FIFO still accepts a push paired with a pop
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(2 ** DEPTH_LOG2);
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    assign empty_o = count_q == '0;
    assign full_o  = count_q == FULL_CNT;
    assign count_o = count_q;
    assign head_o  = mem[rd_ptr_q];
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/uart_wb_fifo.sv
// uart_wb_fifo: Wishbone register front end with TX/RX FIFOs, sticky errors and IRQ for a uart core
module uart_wb_fifo
    import uart_pkg::*;
#(
    parameter int          TX_DEPTH_LOG2 = 4,
    parameter int          RX_DEPTH_LOG2 = 4,
    parameter logic [15:0] EMPTY_READ    = 16'hFFFF,
    parameter int          BUSY_TIMEOUT  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        irq_o,
    output logic        uart_tx_start_o,
    output logic [7:0]  uart_tx_byte_o,
    input  logic        uart_tx_busy_i,
    input  logic        uart_rx_valid_i,
    input  logic [7:0]  uart_rx_byte_i
);
    logic accept, wr, rd, clr, tx_push, tx_pop, rx_pop;
    logic [7:0] tx_head, rx_head;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic tx_full, tx_empty, rx_full, rx_empty;
    tx_state_e state_q, state_d;
    logic [3:0] tmo_q, tmo_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic ack_q, ack_d, irq_q, irq_d, rxovr_q, rxovr_d, txovf_q, txovf_d;
    logic [2:0] irq_en_q, irq_en_d;
    logic [15:0] dat_q, dat_d, rd_val, status;
    logic unused;
    assign unused = &{1'b0, wb_sel_i[1], wb_dat_i[15:8]};

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(tx_push), .din_i(wb_dat_i[7:0]), .pop_i(tx_pop),
        .head_o(tx_head), .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty)
    );
    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(uart_rx_valid_i), .din_i(uart_rx_byte_i), .pop_i(rx_pop),
        .head_o(rx_head), .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        tx_byte_d = tx_byte_q;
        tx_pop    = 1'b0;
        case (state_q)
            IDLE: if (!tx_empty && !uart_tx_busy_i) begin
                tx_pop    = 1'b1;
                tx_byte_d = tx_head;
                state_d   = START;
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // a core that never reports busy is assumed to have sent the byte
                if (uart_tx_busy_i) state_d = WAIT_DONE;
                else if (tmo_q == 4'(BUSY_TIMEOUT - 1)) state_d = IDLE;
                else tmo_d = tmo_q + 4'd1;
            end
            WAIT_DONE: if (!uart_tx_busy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        status               = '0;
        status[ST_RX_EMPTY]  = rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_ACTIVE] = state_q != IDLE || uart_tx_busy_i;
        status[ST_RXOVR]     = rxovr_q;
        status[ST_TXOVF]     = txovf_q;
        accept  = wb_cyc_i && wb_stb_i && !ack_q;
        wr      = accept && wb_we_i && wb_sel_i[0];
        rd      = accept && !wb_we_i;
        clr     = wr && wb_adr_i == REG_STATUS;
        tx_push = wr && wb_adr_i == REG_DATA;
        rx_pop  = rd && wb_sel_i[0] && wb_adr_i == REG_DATA;
        rd_val  = wb_adr_i == REG_DATA   ? (rx_empty ? EMPTY_READ : {8'h00, rx_head}) :
                  wb_adr_i == REG_STATUS ? status :
                  wb_adr_i == REG_IRQ_EN ? {13'd0, irq_en_q} :
                  {8'(tx_count), 8'(rx_count)};
        dat_d    = rd ? rd_val : dat_q;
        ack_d    = accept;
        irq_en_d = wr && wb_adr_i == REG_IRQ_EN ? wb_dat_i[2:0] : irq_en_q;
        // a new overflow on the same edge as a clear keeps the flag set
        rxovr_d = (uart_rx_valid_i && rx_full && !rx_pop) || (rxovr_q && !(clr && wb_dat_i[ST_RXOVR]));
        txovf_d = (tx_push && tx_full && !tx_pop) || (txovf_q && !(clr && wb_dat_i[ST_TXOVF]));
        irq_d   = |(irq_en_q & {rxovr_q || txovf_q, tx_empty && state_q == IDLE, !rx_empty});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            tx_byte_q <= '0;
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
            rxovr_q   <= 1'b0;
            txovf_q   <= 1'b0;
            irq_en_q  <= '0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            tx_byte_q <= tx_byte_d;
            ack_q     <= ack_d;
            irq_q     <= irq_d;
            rxovr_q   <= rxovr_d;
            txovf_q   <= txovf_d;
            irq_en_q  <= irq_en_d;
            dat_q     <= dat_d;
        end
    end

    assign wb_dat_o        = dat_q;
    assign wb_ack_o        = ack_q;
    assign irq_o           = irq_q;
    assign uart_tx_start_o = state_q == START;
    assign uart_tx_byte_o  = tx_byte_q;
endmodule

// File: tb/tb_uart_wb_fifo.sv
// tb_uart_wb_fifo: directed self-checking bench for uart_wb_fifo with a simple core busy model
module tb_uart_wb_fifo;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] adr = '0, sel = '0;
    logic [15:0] dat_in = '0;
    logic we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic busy = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_byte = '0;
    logic [15:0] dat_out;
    logic ack, irq, start;
    logic [7:0] tx_byte;
    int checks = 0, failures = 0, ack_bad = 0;
    bit core_auto = 1'b0;
    logic [7:0] starts[$];
    int start_neg[$];
    int neg_cnt = 0, start_busy = 0, double_start = 0;
    bit prev_start = 1'b0;

    always #5 clk = ~clk;

    uart_wb_fifo dut (
        .clk_i(clk), .rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_in), .wb_dat_o(dat_out),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack), .irq_o(irq),
        .uart_tx_start_o(start), .uart_tx_byte_o(tx_byte), .uart_tx_busy_i(busy),
        .uart_rx_valid_i(rx_valid), .uart_rx_byte_i(rx_byte)
    );

    initial forever begin
        @(negedge clk);
        neg_cnt++;
        if (start) begin
            starts.push_back(tx_byte);
            start_neg.push_back(neg_cnt);
            if (busy) start_busy++;
            if (prev_start) double_start++;
        end
        prev_start = start;
    end

    initial forever begin
        @(negedge clk);
        if (core_auto && start) begin
            @(negedge clk);
            busy = 1'b1;
            repeat (20) @(negedge clk);
            busy = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [15:0] d, output logic [15:0] q);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_in = d; sel = 2'b11;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (ack !== 1'b1) ack_bad++;
        q = dat_out;
        @(posedge clk); #1;
        if (ack !== 1'b0) ack_bad++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        logic [15:0] junk;
        bus(1'b1, a, d, junk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] q);
        bus(1'b0, a, 16'h0000, q);
    endtask

    task automatic test_reset;
        logic [15:0] q;
        logic [3:0] pat;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack, irq, start} !== 3'b000 || dat_out !== 16'h0 || tx_byte !== 8'h0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b irq=%b start=%b dat=%h byte=%h want all 0", ack, irq, start, dat_out, tx_byte);
        end
        @(negedge clk) rst_n = 1'b1;
        rd(2'd1, q);
        checks++;
        if (q !== 16'h0005) begin failures++; $display("FAIL reset_status got=%h want=0005", q); end
        rd(2'd3, q);
        checks++;
        if (q !== 16'h0000) begin failures++; $display("FAIL reset_levels got=%h want=0000", q); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd3; sel = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pat[i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        checks++;
        if (pat !== 4'b0101) begin failures++; $display("FAIL held_strobe_ack got=%b want=0101", pat); end
    endtask

    task automatic test_tx;
        logic [15:0] q;
        int n0;
        n0 = starts.size();
        core_auto = 1'b1;
        wr(2'd0, 16'h0041);
        wr(2'd0, 16'h0042);
        repeat (80) @(posedge clk);
        #1;
        core_auto = 1'b0;
        checks++;
        if (starts.size() != n0 + 2) begin failures++; $display("FAIL tx_start_count got=%0d want=2", starts.size() - n0); end
        if (starts.size() >= n0 + 2) begin
            checks++;
            if (starts[n0] !== 8'h41 || starts[n0+1] !== 8'h42) begin
                failures++;
                $display("FAIL tx_bytes got=%h,%h want=41,42", starts[n0], starts[n0+1]);
            end
            checks++;
            if (start_neg[n0+1] - start_neg[n0] != 23) begin
                failures++;
                $display("FAIL tx_start_gap got=%0d want=23", start_neg[n0+1] - start_neg[n0]);
            end
        end
        checks++;
        if (start_busy != 0) begin failures++; $display("FAIL tx_start_while_busy got=%0d want=0", start_busy); end
        checks++;
        if (double_start != 0) begin failures++; $display("FAIL tx_start_width got=%0d long pulses want=0", double_start); end
        rd(2'd1, q);
        checks++;
        if (q !== 16'h0005) begin failures++; $display("FAIL tx_status_done got=%h want=0005", q); end
    endtask

    task automatic test_tx_overflow;
        logic [15:0] q;
        int n0, bad;
        busy = 1'b1;
        for (int i = 0; i < 17; i++) wr(2'd0, 16'h0010 + 16'(i));
        rd(2'd3, q);
        checks++;
        if (q !== 16'h1000) begin failures++; $display("FAIL txovf_levels got=%h want=1000", q); end
        rd(2'd1, q);
        checks++;
        if (q !== 16'h0059) begin failures++; $display("FAIL txovf_status got=%h want=0059", q); end
        wr(2'd1, 16'h0040);
        rd(2'd1, q);
        checks++;
        if (q !== 16'h0019) begin failures++; $display("FAIL txovf_clear got=%h want=0019", q); end
        n0 = starts.size();
        busy = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        checks++;
        if (starts.size() != n0 + 16) begin failures++; $display("FAIL txovf_drain_count got=%0d want=16", starts.size() - n0); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (n0 + i < starts.size() && starts[n0+i] !== 8'h10 + 8'(i)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL txovf_drain_order got=%0d wrong bytes want=0", bad); end
        rd(2'd3, q);
        checks++;
        if (q !== 16'h0000) begin failures++; $display("FAIL txovf_drain_levels got=%h want=0000", q); end
    endtask

    task automatic test_rx;
        logic [15:0] q;
        logic i1, i2;
        wr(2'd2, 16'h0001);
        @(negedge clk);
        rx_valid = 1'b1; rx_byte = 8'h5A;
        @(negedge clk);
        rx_valid = 1'b0;
        i1 = irq;
        @(negedge clk);
        i2 = irq;
        checks++;
        if ({i1, i2} !== 2'b01) begin failures++; $display("FAIL rx_irq_latency got=%b%b want=01", i1, i2); end
        rd(2'd0, q);
        checks++;
        if (q !== 16'h005A) begin failures++; $display("FAIL rx_data got=%h want=005a", q); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rx_irq_fall got=%b want=0", irq); end
        rd(2'd0, q);
        checks++;
        if (q !== 16'hFFFF) begin failures++; $display("FAIL rx_empty_read got=%h want=ffff", q); end
        wr(2'd2, 16'h0000);
    endtask

    task automatic test_rx_full;
        logic [15:0] q, exp;
        int bad;
        @(negedge clk);
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_byte = 8'h80 + 8'(i);
            @(negedge clk);
        end
        rx_byte = 8'h90;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd0; sel = 2'b11;
        @(posedge clk); #1;
        rx_valid = 1'b0; cyc = 1'b0; stb = 1'b0;
        q = dat_out;
        checks++;
        if (q !== 16'h0080 || ack !== 1'b1) begin failures++; $display("FAIL rx_pop_push_full got=%h ack=%b want=0080 ack=1", q, ack); end
        @(posedge clk); #1;
        rd(2'd1, q);
        checks++;
        if (q !== 16'h0006) begin failures++; $display("FAIL rx_full_status got=%h want=0006", q); end
        rd(2'd3, q);
        checks++;
        if (q !== 16'h0010) begin failures++; $display("FAIL rx_full_levels got=%h want=0010", q); end
        @(negedge clk);
        rx_valid = 1'b1; rx_byte = 8'hAA;
        @(negedge clk);
        rx_valid = 1'b0;
        rd(2'd1, q);
        checks++;
        if (q !== 16'h0026) begin failures++; $display("FAIL rxovr_status got=%h want=0026", q); end
        wr(2'd2, 16'h0004);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL rxovr_irq got=%b want=1", irq); end
        @(negedge clk);
        rx_valid = 1'b1; rx_byte = 8'hBB;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd1; dat_in = 16'h0020; sel = 2'b11;
        @(posedge clk); #1;
        rx_valid = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rd(2'd1, q);
        checks++;
        if (q !== 16'h0026) begin failures++; $display("FAIL rxovr_set_wins got=%h want=0026", q); end
        wr(2'd1, 16'h0020);
        rd(2'd1, q);
        checks++;
        if (q !== 16'h0006) begin failures++; $display("FAIL rxovr_clear got=%h want=0006", q); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rxovr_irq_clear got=%b want=0", irq); end
        wr(2'd2, 16'h0000);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            rd(2'd0, q);
            exp = i < 15 ? 16'h0081 + 16'(i) : 16'h0090;
            if (q !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rx_drain_order got=%0d wrong reads want=0", bad); end
        rd(2'd0, q);
        checks++;
        if (q !== 16'hFFFF) begin failures++; $display("FAIL rx_drain_empty got=%h want=ffff", q); end
    endtask

    task automatic test_timeout;
        int n0, k;
        wr(2'd2, 16'h0002);
        n0 = starts.size();
        wr(2'd0, 16'h0077);
        k = 0;
        while (irq !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (k != 6) begin failures++; $display("FAIL timeout_cycles got=%0d want=6", k); end
        checks++;
        if (starts.size() != n0 + 1 || tx_byte !== 8'h77) begin
            failures++;
            $display("FAIL timeout_start got=%0d starts byte=%h want=1 starts byte=77", starts.size() - n0, tx_byte);
        end
        wr(2'd2, 16'h0000);
    endtask

    task automatic test_reset_mid;
        logic [15:0] q;
        busy = 1'b0;
        wr(2'd0, 16'h0033);
        busy = 1'b1;
        wr(2'd0, 16'h0034);
        wr(2'd0, 16'h0035);
        @(negedge clk);
        rx_valid = 1'b1; rx_byte = 8'h11;
        @(negedge clk);
        rx_valid = 1'b0;
        rd(2'd1, q);
        checks++;
        if (q !== 16'h0010 || tx_byte !== 8'h33) begin
            failures++;
            $display("FAIL mid_frame_state got=%h byte=%h want=0010 byte=33", q, tx_byte);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, irq, start} !== 3'b000 || dat_out !== 16'h0 || tx_byte !== 8'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs ack=%b irq=%b start=%b dat=%h byte=%h want all 0", ack, irq, start, dat_out, tx_byte);
        end
        busy = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        rd(2'd3, q);
        checks++;
        if (q !== 16'h0000) begin failures++; $display("FAIL mid_reset_levels got=%h want=0000", q); end
        rd(2'd1, q);
        checks++;
        if (q !== 16'h0005) begin failures++; $display("FAIL mid_reset_status got=%h want=0005", q); end
        checks++;
        if (ack_bad != 0) begin failures++; $display("FAIL ack_pulses got=%0d bad want=0", ack_bad); end
    endtask

    initial begin
        test_reset;
        test_tx;
        test_tx_overflow;
        test_rx;
        test_rx_full;
        test_timeout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
